apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- Single-outstanding APB requester that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers.
- Sits directly upstream of the register-bank APB slave and drives its PSEL/PENABLE/PWRITE/PADDR/PWDATA.
- The slave has no PREADY and registers PRDATA one edge after ACCESS, so the master captures read data in a dedicated post-ACCESS state.
- Returns a one-cycle response pulse per command: read data, or an error for a misaligned address.

Parameters:
ADDR_W, 32, width of cmd_addr and PADDR
DATA_W, 32, width of cmd_wdata, PWDATA, PRDATA, rsp_rdata

Ports:
PCLK  in  1  clock, all state updates on rising edge
PRESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  master can accept a command (high only in IDLE)
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address; must be word aligned
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  qualifies rsp_valid; 1 = misaligned command rejected
rsp_rdata  out  DATA_W  read data; valid with rsp_valid for reads, holds until next read completes
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data from slave (registered inside slave)

Behaviour:
- Reset (PRESET=1, asynchronous): state=IDLE. PSEL, PENABLE, PWRITE, rsp_valid and rsp_err are 0. PADDR, PWDATA and rsp_rdata are 0. cmd_ready=1 once reset is released. Reset mid-transfer drops PSEL/PENABLE immediately, with no response for the aborted command.
- FSM states: IDLE, SETUP, ACCESS, RDCAP. All APB outputs are registered.
- IDLE: cmd_ready=1. On cmd_valid, latch write/addr/wdata into hold registers.
  - If cmd_addr[1:0]!=0: stay IDLE, no APB activity. Next cycle rsp_valid=1, rsp_err=1; rsp_rdata unchanged.
  - Otherwise go to SETUP.
- SETUP (1 cycle): PSEL=1, PENABLE=0. PADDR, PWRITE and PWDATA come from the hold registers. Go to ACCESS.
- ACCESS (1 cycle): PSEL=1, PENABLE=1, other APB outputs unchanged.
  - Write: go to IDLE; rsp_valid=1, rsp_err=0 during that IDLE cycle.
  - Read: go to RDCAP.
- RDCAP (1 cycle): PSEL=0, PENABLE=0. PRDATA now holds the slave's registered value. On exit edge: rsp_rdata<=PRDATA, rsp_valid<=1, rsp_err<=0. Go to IDLE.
- cmd_ready is 0 in SETUP, ACCESS and RDCAP. cmd_valid during these states is ignored; the command source holds it.
- Throughput: write 3 cycles, read 4 cycles, error 1 cycle per command.
- A new command may be accepted in the same IDLE cycle that rsp_valid is high.
- rsp_valid is always a single-cycle pulse; rsp_err=0 whenever rsp_valid=0.
- PADDR, PWDATA and PWRITE keep their last values while idle. PSEL=0 outside SETUP/ACCESS.
- No PREADY and no PSLVERR: every ACCESS completes in one cycle.

Test Plan:
1. Reset release, read addr 0x8 -> SETUP then ACCESS with PADDR=0x8, PWRITE=0; rsp_valid 4 cycles after accept with rsp_rdata=0x12349876, rsp_err=0.
2. Write 0xDEADBEEF to 0x4, then read 0x4 -> write response after 3 cycles; read response with rsp_rdata=0xDEADBEEF; PSEL high exactly 2 cycles per transfer.
3. Misaligned read at 0x6 -> PSEL never asserted; rsp_valid=1, rsp_err=1 next cycle; rsp_rdata keeps previous value.
4. cmd_valid held continuously with write 0x0 then read 0xC -> no gap beyond the IDLE cycle; cmd_ready low during SETUP/ACCESS/RDCAP; second command accepted in the IDLE cycle coinciding with the first response pulse.
5. Assert PRESET during ACCESS of a write to 0x4 -> PSEL/PENABLE drop to 0 before the next clock edge, no rsp_valid. Slave reset restores 0xA5A50000, and a subsequent read of 0x4 returns it.
6. Read 0x0 with slave reset -> rsp_rdata=0x00000000 with rsp_err=0, confirming the zero-value read is distinguished from the error path.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// Command/response and APB signal bundle for apb_cmd_master.
// master modport is the requester side; slave modport is its peer.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;

  modport master (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_wdata,
    input  PRDATA,
    output cmd_ready,
    output rsp_valid,
    output rsp_err,
    output rsp_rdata,
    output PSEL,
    output PENABLE,
    output PWRITE,
    output PADDR,
    output PWDATA
  );

  modport slave (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_wdata,
    output PRDATA,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_err,
    input  rsp_rdata,
    input  PSEL,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    input  PWDATA
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB requester: valid/ready command in,
// SETUP/ACCESS out, one-cycle response pulse back.
module apb_cmd_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic           PCLK,
  input logic           PRESET,
  apb_cmd_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RDCAP
  } state_t;

  state_t            state_q, state_d;
  logic              psel_q, psel_d;
  logic              pen_q, pen_d;
  logic              pwr_q, pwr_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rv_q, rv_d;
  logic              re_q, re_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              misaligned;

  assign misaligned = |bus.cmd_addr[1:0];

  // APB address/data registers double as the command hold registers
  always_comb begin
    state_d  = state_q;
    psel_d   = 1'b0;
    pen_d    = 1'b0;
    pwr_d    = pwr_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rv_d     = 1'b0;
    re_d     = 1'b0;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (misaligned) begin
            rv_d = 1'b1;
            re_d = 1'b1;
          end else begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            pwr_d    = bus.cmd_write;
            paddr_d  = bus.cmd_addr;
            pwdata_d = bus.cmd_wdata;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        psel_d  = 1'b1;
        pen_d   = 1'b1;
      end
      ACCESS: begin
        if (pwr_q) begin
          state_d = IDLE;
          rv_d    = 1'b1;
        end else begin
          state_d = RDCAP;
        end
      end
      RDCAP: begin
        // slave PRDATA is registered, valid only now
        state_d = IDLE;
        rv_d    = 1'b1;
        rdata_d = bus.PRDATA;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwr_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rv_q     <= 1'b0;
      re_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwr_q    <= pwr_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rv_q     <= rv_d;
      re_q     <= re_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) && !PRESET;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = pen_q;
  assign bus.PWRITE    = pwr_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_err   = re_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: register-bank slave, memory
// model of expected responses, directed plus random commands.
module tb_apb_cmd_master;

  logic PCLK;
  logic PRESET;
  int   vecs;
  int   errs;

  logic [31:0] smem [16];
  logic [31:0] mm [16];
  logic [31:0] exp_rdata;

  apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  function automatic logic [31:0] rst_val(input int i);
    if (i == 0) return 32'h0000_0000;
    if (i == 1) return 32'hA5A5_0000;
    if (i == 2) return 32'h1234_9876;
    return 32'h0101_0101 * i;
  endfunction

  // register-bank slave: PRDATA registered at the ACCESS edge
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < 16; i++) smem[i] <= rst_val(i);
      bus.PRDATA <= '0;
    end else if (bus.PSEL && bus.PENABLE) begin
      if (bus.PWRITE) smem[bus.PADDR[5:2]] <= bus.PWDATA;
      else bus.PRDATA <= smem[bus.PADDR[5:2]];
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mm[i] = rst_val(i);
    exp_rdata = '0;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic w,
                        input logic [31:0] a,
                        input logic [31:0] d);
    int lat;
    int pc;
    int exp_lat;
    logic ok;
    logic [31:0] exp_d;
    ok = (a[1:0] == 2'b00);
    exp_lat = !ok ? 1 : (w ? 3 : 4);
    exp_d = (ok && !w) ? mm[a[5:2]] : exp_rdata;
    @(negedge PCLK);
    chk("ready_idle", bus.cmd_ready, 1);
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_valid = 1'b1;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    lat = 0;
    pc  = 0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.PSEL) pc++;
      if (ok && k == 1) begin
        chk("setup_pen", bus.PENABLE, 0);
        chk("setup_paddr", bus.PADDR, a);
        chk("setup_pwrite", bus.PWRITE, w);
        if (w) chk("setup_pwdata", bus.PWDATA, d);
        chk("busy_ready", bus.cmd_ready, 0);
      end
      if (ok && k == 2) chk("access_pen", bus.PENABLE, 1);
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
      @(negedge PCLK);
    end
    chk("latency", lat, exp_lat);
    chk("psel_cycles", pc, ok ? 2 : 0);
    chk("rsp_err", bus.rsp_err, !ok);
    chk("rsp_rdata", bus.rsp_rdata, exp_d);
    @(negedge PCLK);
    chk("pulse_end", bus.rsp_valid, 0);
    chk("err_idle", bus.rsp_err, 0);
    if (ok && w) mm[a[5:2]] = d;
    exp_rdata = exp_d;
  endtask

  initial begin
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    vecs = 0;
    errs = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    PRESET = 1'b1;
    model_reset();
    #12;
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_pen", bus.PENABLE, 0);
    chk("rst_pwrite", bus.PWRITE, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_rv", bus.rsp_valid, 0);
    chk("rst_re", bus.rsp_err, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    @(negedge PCLK);
    PRESET = 1'b0;

    do_cmd(1'b0, 32'h8, 32'h0);
    do_cmd(1'b1, 32'h4, 32'hDEAD_BEEF);
    do_cmd(1'b0, 32'h4, 32'h0);
    do_cmd(1'b0, 32'h6, 32'h0);

    // back-to-back: source holds cmd_valid across both commands
    @(negedge PCLK);
    chk("b2b_ready0", bus.cmd_ready, 1);
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h55AA_1234;
    bus.cmd_valid = 1'b1;
    @(negedge PCLK);
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'hC;
    chk("b2b_ready_setup", bus.cmd_ready, 0);
    @(negedge PCLK);
    chk("b2b_ready_access", bus.cmd_ready, 0);
    chk("b2b_pen", bus.PENABLE, 1);
    @(negedge PCLK);
    chk("b2b_wr_rsp", bus.rsp_valid, 1);
    chk("b2b_wr_err", bus.rsp_err, 0);
    chk("b2b_ready_rsp", bus.cmd_ready, 1);
    mm[0] = 32'h55AA_1234;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    chk("b2b_rd_ready", bus.cmd_ready, 0);
    chk("b2b_rd_psel", bus.PSEL, 1);
    chk("b2b_rd_paddr", bus.PADDR, 32'hC);
    @(negedge PCLK);
    chk("b2b_rd_ready2", bus.cmd_ready, 0);
    @(negedge PCLK);
    chk("b2b_rdcap_ready", bus.cmd_ready, 0);
    chk("b2b_rdcap_psel", bus.PSEL, 0);
    @(negedge PCLK);
    chk("b2b_rd_rsp", bus.rsp_valid, 1);
    chk("b2b_rd_data", bus.rsp_rdata, mm[3]);
    exp_rdata = mm[3];
    @(negedge PCLK);
    chk("b2b_pulse_end", bus.rsp_valid, 0);

    // reset in the ACCESS cycle of a write
    @(negedge PCLK);
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h4;
    bus.cmd_wdata = 32'h1111_2222;
    bus.cmd_valid = 1'b1;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("abort_psel_pre", bus.PSEL, 1);
    chk("abort_pen_pre", bus.PENABLE, 1);
    #1 PRESET = 1'b1;
    #1;
    chk("abort_psel", bus.PSEL, 0);
    chk("abort_pen", bus.PENABLE, 0);
    model_reset();
    @(negedge PCLK);
    chk("abort_rv", bus.rsp_valid, 0);
    PRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("abort_no_rsp", bus.rsp_valid, 0);
    end
    do_cmd(1'b0, 32'h4, 32'h0);
    do_cmd(1'b0, 32'h0, 32'h0);

    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom % 2);
      a = 32'($urandom_range(0, 63));
      if ($urandom % 4 != 0) a[1:0] = 2'b00;
      d = $urandom;
      do_cmd(w, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
